// File: rtl/sum_high_drain_if.sv
// Token-in / result-out bundle of the split-adder drain stage.
// The master side feeds tokens and accepts results; the slave side is the drain stage.
interface sum_high_drain_if #(
   parameter int LOW_W  = 9,
   parameter int HIGH_W = 8,
   parameter int CNT_W  = 16
);
   logic                     en_pipe_i;
   logic                     ready_i;
   logic                     N_i;
   logic [LOW_W-1:0]         sum_low_i;
   logic                     Co_i;
   logic [HIGH_W-1:0]        A_high_i;
   logic [HIGH_W-1:0]        B_high_i;
   logic [HIGH_W+LOW_W:0]    result_o;
   logic                     N_o;
   logic                     valid_o;
   logic                     accept_i;
   logic                     space_o;
   logic                     overflow_o;
   logic [CNT_W-1:0]         result_cnt_o;

   modport master (
      output en_pipe_i, ready_i, N_i, sum_low_i, Co_i, A_high_i, B_high_i, accept_i,
      input  result_o, N_o, valid_o, space_o, overflow_o, result_cnt_o
   );

   modport slave (
      input  en_pipe_i, ready_i, N_i, sum_low_i, Co_i, A_high_i, B_high_i, accept_i,
      output result_o, N_o, valid_o, space_o, overflow_o, result_cnt_o
   );
endinterface

// File: rtl/sum_high_drain.sv
// Final split-adder stage: completes the high half, assembles the full sum and
// buffers results in a small FIFO drained over a valid/accept handshake.
module sum_high_drain #(
   parameter int LOW_W  = 9,
   parameter int HIGH_W = 8,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   sum_high_drain_if.slave   bus
);
   localparam int RES_W = HIGH_W + 1 + LOW_W;
   localparam int ENT_W = RES_W + 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CQ_W  = $clog2(DEPTH + 1);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CQ_W-1:0]  count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RES_W-1:0] result_q;
   logic             n_q;
   logic             valid_q;
   logic             space_q;
   logic             push_s, pop_s, valid_d;
   logic [ENT_W-1:0] entry_s, head_s;

   function automatic logic [HIGH_W:0] high_sum(input logic [HIGH_W-1:0] a,
                                                input logic [HIGH_W-1:0] b,
                                                input logic              co);
      return {1'b0, a} + {1'b0, b} + {{HIGH_W{1'b0}}, co};
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Next-state: push/pop bookkeeping and the head entry the output registers will load
   always_comb begin
      push_s  = bus.en_pipe_i & bus.ready_i;
      pop_s   = valid_q & bus.accept_i;
      entry_s = {bus.N_i, high_sum(bus.A_high_i, bus.B_high_i, bus.Co_i), bus.sum_low_i};
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (pop_s) begin
         rd_d  = next_ptr(rd_q);
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         rd_d  = rd_q;
      end
      case ({push_s, pop_s})
         2'b10: begin
            if (count_q == CQ_W'(DEPTH)) begin
               ovf_d = 1'b1;
            end else begin
               mem_d[wr_q] = entry_s;
               wr_d        = next_ptr(wr_q);
               count_d     = count_q + CQ_W'(1);
            end
         end
         // When full, the slot being overwritten is the one just popped into the output register
         2'b11: begin
            mem_d[wr_q] = entry_s;
            wr_d        = next_ptr(wr_q);
         end
         2'b01: begin
            count_d = count_q - CQ_W'(1);
         end
         default: begin
            count_d = count_q;
         end
      endcase
      valid_d = (count_d != CQ_W'(0));
      head_s  = mem_d[rd_d];
   end

   // State and registered outputs; outputs hold the last popped entry while empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ENT_W{1'b0}};
         end
         wr_q     <= {PTR_W{1'b0}};
         rd_q     <= {PTR_W{1'b0}};
         count_q  <= {CQ_W{1'b0}};
         ovf_q    <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         result_q <= {RES_W{1'b0}};
         n_q      <= 1'b0;
         valid_q  <= 1'b0;
         space_q  <= 1'b1;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         space_q <= (count_d < CQ_W'(DEPTH));
         if (valid_d) begin
            result_q <= head_s[RES_W-1:0];
            n_q      <= head_s[ENT_W-1];
         end else begin
            result_q <= result_q;
            n_q      <= n_q;
         end
      end
   end

   assign bus.result_o     = result_q;
   assign bus.N_o          = n_q;
   assign bus.valid_o      = valid_q;
   assign bus.space_o      = space_q;
   assign bus.overflow_o   = ovf_q;
   assign bus.result_cnt_o = cnt_q;
endmodule
